seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexes the 6-digit seven-segment display by driving the 3-bit select of the 6:1 x 4-bit digit mux.
//  It also drives the matching active-low digit anodes. A dead-time gap with all anodes off is inserted between digits to stop ghosting.
//  Sits between the top-level display path and the board anode pins; segment decode stays downstream of the mux.
// PARAMETERS
//  SCAN_DIV    50000  clk cycles per digit slot (dead time included); 50 MHz -> 1 kHz digit rate
//  DEAD_CYC    500    cycles per slot with all anodes off; legal range 1 <= DEAD_CYC < SCAN_DIV
//  CNT_W       16     slot counter width; must satisfy 2**CNT_W > SCAN_DIV
//  BLINK_HALF  12500000  blink half-period in clk cycles (used only with SEG_BLINK_EN)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  en          in   1  scan enable; 0 = display dark
//  dig_en      in   6  per-digit enable mask; 0 = digit never lit
//  sel         out  3  digit select to mux S; values 0..5 only
//  an          out  6  digit anodes, active-low, registered
//  frame_tick  out  1  one-cycle pulse when sel wraps 5 -> 0
//  blink       in   6  per-digit blink mask (port exists only with SEG_BLINK_EN)
// BEHAVIOUR
//  Reset values:
//  - sel = 0, an = 6'b111111, frame_tick = 0, state = IDLE, counters = 0.
//  FSM states IDLE, DEAD, ON (all outputs registered):
//  - IDLE: an all 1, sel = 0, counter = 0. If en = 1, go to DEAD on the next edge.
//  - DEAD: an all 1; counter counts 0..DEAD_CYC-1, then go to ON.
//  - ON: an[sel] = ~dig_en[sel]; all other an bits = 1. Counter continues to SCAN_DIV-1.
//  - End of ON (same edge for all of the following):
//    - counter clears;
//    - sel advances (5 -> 0 wrap, never 6 or 7);
//    - an returns to all 1;
//    - state goes to DEAD.
//  - frame_tick = 1 for exactly the one cycle after the 5 -> 0 advance.
//  Invariants and timing:
//  - sel never changes while any anode is low.
//  - Slot period is exactly SCAN_DIV cycles; frame period is 6*SCAN_DIV.
//  - The first anode goes low DEAD_CYC+1 cycles after en rises.
//  Boundary conditions:
//  - en falls in any state: next edge gives IDLE, an all 1, sel = 0, no frame_tick.
//  - rst mid-slot: identical to the reset values above on the next edge.
//  - dig_en change during ON: an reflects the new mask on the next edge; slot timing is unaffected.
//  - dig_en = 0: scanning and frame_tick continue; an stays all 1.
// CONFIGURATION
//  `SEG_BLINK_EN defined:
//  - Adds the blink port, a BLINK_HALF counter and a phase flop (phase resets to 0, toggles every BLINK_HALF cycles).
//  - In ON, a digit is lit only if dig_en[sel] & ~(blink[sel] & phase).
//  - The blink counter runs independently of en.
//  Not defined:
//  - No blink port and no blink counter; lit condition is dig_en[sel] only.
// STRUCTURE
//  seg_defs.vh: NUM_DIG = 6, AN_OFF = 6'b111111, SEL_LAST = 3'd5, state codes ST_IDLE, ST_DEAD, ST_ON.
//  Sub-module scan_timer: slot counter (0..SCAN_DIV-1) giving dead_done and slot_done strobes.
//  The FSM, sel, an and blink logic stay in seg_scan_ctrl.
// TESTING (SCAN_DIV=10, DEAD_CYC=2, BLINK_HALF=25)
//  1. rst=1 for 3 cycles, en=1 -> an=111111, sel=0 throughout reset.
//     After release, an=111110 appears at cycle 3; after 10 more cycles sel=1, an=111101.
//  2. dig_en=6'h3F, run 60 cycles -> sel sequence 0..5, each held 10 cycles.
//     frame_tick high exactly once, at the cycle sel returns to 0; an never has two zeros.
//  3. Every cycle where sel changes -> an==111111 on that cycle and the next DEAD_CYC-1 cycles.
//  4. dig_en=6'b101010 -> digits 0, 2, 4 never lit; digits 1, 3, 5 lit 8 of 10 cycles per slot.
//  5. en dropped in the middle of digit 3's ON -> next cycle an=111111, sel=0.
//     en re-raised -> restart from digit 0 after dead time.
//  6. SEG_BLINK_EN with blink=6'b000001 -> digit 0 dark in alternate 25-cycle phases, other digits unaffected.
//     Without the macro, the same bench minus the blink port passes tests 1-5 unchanged.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and FSM state encoding for the seven-segment scan controller.
//   NUM_DIG  : number of multiplexed digits
//   SEL_W    : width of the digit select
//   AN_OFF   : anode pattern with every digit dark (anodes are active-low)
//   SEL_LAST : highest legal select value; the scan wraps to 0 after it
//   state_t  : IDLE / DEAD / ON scan states
package seg_scan_ctrl_pkg;

  localparam int unsigned NUM_DIG = 6;
  localparam int unsigned SEL_W   = 3;

  localparam logic [NUM_DIG-1:0] AN_OFF   = 6'b111111;
  localparam logic [SEL_W-1:0]   SEL_LAST = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_scan_timer.sv
// Slot counter for the digit scan: runs 0..SCAN_DIV-1 while i_run is high and
// flags the last dead-time cycle and the last cycle of the slot.
//   clk, rst        : clock, synchronous active-high reset
//   i_run           : count enable; low holds the counter at 0
//   o_dead_done_c   : counter is on the last dead-time cycle (combinational)
//   o_slot_done_c   : counter is on the last cycle of the slot (combinational)
module seg_scan_ctrl_scan_timer #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEAD_CYC = 500,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_dead_done_c,
  output logic o_slot_done_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_dead_done_c = (r_cnt == CNT_W'(DEAD_CYC - 1));
  assign o_slot_done_c = (r_cnt == CNT_W'(SCAN_DIV - 1));

  // Counter clears whenever scanning stops so every restart begins a fresh slot.
  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_cnt <= '0;
    end else if (o_slot_done_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan controller. Drives the 6:1 digit mux select and
// the active-low anodes, with an all-dark dead-time gap at the start of every
// slot to suppress ghosting.
//   clk, rst    : clock, synchronous active-high reset
//   en          : scan enable; low forces IDLE (display dark, sel = 0)
//   dig_en      : per-digit enable mask
//   sel         : digit select to the mux, 0..5 (registered)
//   an          : digit anodes, active-low (registered)
//   frame_tick  : one-cycle pulse on the 5 -> 0 select wrap (registered)
//   blink       : per-digit blink mask, present only with SEG_BLINK_EN
// Build option SEG_BLINK_EN adds the blink port and a free-running blink phase.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEAD_CYC   = 500,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned BLINK_HALF = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_DIG-1:0] dig_en,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_DIG-1:0] an,
  output logic               frame_tick
`ifdef SEG_BLINK_EN
  ,
  input  logic [NUM_DIG-1:0] blink
`endif
);

  // Reject illegal parameter sets at elaboration.
  if (DEAD_CYC < 1 || DEAD_CYC >= SCAN_DIV || 64'(SCAN_DIV) >= (64'd1 << CNT_W)
      || BLINK_HALF < 1) begin : g_bad_param
    $error("seg_scan_ctrl: illegal SCAN_DIV/DEAD_CYC/CNT_W/BLINK_HALF");
  end

  state_t               r_state, w_state_nxt;
  logic [SEL_W-1:0]     r_sel, w_sel_nxt;
  logic [NUM_DIG-1:0]   r_an, w_an_nxt;
  logic                 r_frame_tick, w_frame_tick_nxt;
  logic                 w_dead_done, w_slot_done;
  logic                 w_run, w_lit;

  assign w_run = en && (r_state != ST_IDLE);

  seg_scan_ctrl_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .DEAD_CYC (DEAD_CYC),
    .CNT_W    (CNT_W)
  ) u_scan_timer (
    .clk           (clk),
    .rst           (rst),
    .i_run         (w_run),
    .o_dead_done_c (w_dead_done),
    .o_slot_done_c (w_slot_done)
  );

`ifdef SEG_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BLINK_W-1:0] r_blink_cnt;
  logic               r_phase;

  // Blink phase is free-running so the blink rate does not depend on en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  assign w_lit = dig_en[r_sel] & ~(blink[r_sel] & r_phase);
`else
  assign w_lit = dig_en[r_sel];
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_an         <= AN_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_an         <= w_an_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end
  end

  // Next state and next outputs; anodes default dark so sel only moves while dark.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_an_nxt         = AN_OFF;
    w_frame_tick_nxt = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_sel_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_DEAD;
          w_sel_nxt   = '0;
        end
        ST_DEAD: begin
          if (w_dead_done) begin
            w_state_nxt       = ST_ON;
            w_an_nxt[r_sel]   = ~w_lit;
          end
        end
        ST_ON: begin
          if (w_slot_done) begin
            w_state_nxt      = ST_DEAD;
            w_sel_nxt        = (r_sel == SEL_LAST) ? '0 : SEL_W'(r_sel + SEL_W'(1));
            w_frame_tick_nxt = (r_sel == SEL_LAST);
          end else begin
            w_an_nxt[r_sel] = ~w_lit;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_sel_nxt   = '0;
        end
      endcase
    end
  end

  assign sel        = r_sel;
  assign an         = r_an;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=10, DEAD_CYC=2, BLINK_HALF=25.
// Expected outputs come from slot arithmetic: idx counts edges since the scan
// left IDLE; each slot is 10 cycles, the first 2 dark, and sel = (idx/10)%6.
module tb_seg_scan_ctrl;

  localparam int SD = 10;
  localparam int DC = 2;
  localparam int BH = 25;

  logic       clk;
  logic       rst;
  logic       en;
  logic [5:0] dig_en;
  logic [2:0] sel;
  logic [5:0] an;
  logic       frame_tick;
`ifdef SEG_BLINK_EN
  logic [5:0] blink;
`endif
  logic [5:0] bl_m;

  int n_checks;
  int n_fail;
  int idx;
  int nb;
  int ft_cnt;

  seg_scan_ctrl #(
    .SCAN_DIV   (SD),
    .DEAD_CYC   (DC),
    .CNT_W      (4),
    .BLINK_HALF (BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dig_en     (dig_en),
    .sel        (sel),
    .an         (an),
    .frame_tick (frame_tick)
`ifdef SEG_BLINK_EN
    ,
    .blink      (blink)
`endif
  );

  always #5 clk = ~clk;

  // Anode pattern expected after edge number i of the scan (i < 0 means IDLE/reset).
  function automatic logic [5:0] exp_an(int i, int n, logic [5:0] de, logic [5:0] bl);
    int         s;
    logic       ph;
    logic [5:0] r;
    r = 6'h3F;
    if (i >= 0 && (i % SD) >= DC) begin
      s    = (i / SD) % 6;
      ph   = (((n - 1) / BH) % 2) == 1;
      r[s] = ~(de[s] & ~(bl[s] & ph));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [5:0] obs,
                     input logic [5:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    idx = (rst || !en) ? -1 : idx + 1;
    nb  = rst ? 0 : nb + 1;
    #1;
    chk("an", idx, an, exp_an(idx, nb, dig_en, bl_m));
    chk("sel", idx, {3'b000, sel}, (idx < 0) ? 6'd0 : 6'((idx / SD) % 6));
    chk("frame_tick", idx, {5'b00000, frame_tick},
        {5'b00000, 1'((idx > 0) && (idx % (6 * SD) == 0))});
    if (frame_tick) ft_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    en       = 1'b1;
    dig_en   = 6'h3F;
    bl_m     = 6'h00;
`ifdef SEG_BLINK_EN
    blink    = 6'h00;
`endif
    n_checks = 0;
    n_fail   = 0;
    idx      = -1;
    nb       = 0;
    ft_cnt   = 0;

    // Reset held three cycles with en already high.
    run(3);
    rst = 1'b0;

    // Full frame with all digits enabled; one frame_tick at the wrap.
    ft_cnt = 0;
    run(61);
    chk("ft_once_full", idx, 6'(ft_cnt), 6'd1);

    // Mask change in the middle of digit 3's lit phase.
    run(34);
    dig_en = 6'b010101;
    run(6);

    // Alternate mask: even digits dark, odd digits lit 8 of 10 cycles.
    dig_en = 6'b101010;
    ft_cnt = 0;
    run(60);
    chk("ft_once_alt", idx, 6'(ft_cnt), 6'd1);

    // Drop en while digit 3 is lit, idle a little, then restart.
    run(55);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(15);

    // All digits masked: scanning and frame_tick continue with dark anodes.
    dig_en = 6'h00;
    ft_cnt = 0;
    run(60);
    chk("ft_once_dark", idx, 6'(ft_cnt), 6'd1);

    // Reset asserted mid-slot, then released.
    dig_en = 6'h3F;
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(14);

`ifdef SEG_BLINK_EN
    // Digit 0 blinks with a 25-cycle phase; other digits unaffected.
    bl_m  = 6'b000001;
    blink = 6'b000001;
    run(150);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
